// File: rtl/alu_share_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_share_arbiter_if
// Purpose  : Bundles the two requester channels, the two response channels,
//            the shared ALU hookup and the status outputs of the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_share_arbiter_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
);
    // Requester 0 / 1 operation channels
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [3:0]       req0_op;
    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic [3:0]       req1_op;

    // Requester 0 / 1 response channels
    logic             rsp0_valid;
    logic             rsp0_ready;
    logic [WIDTH-1:0] rsp0_data;
    logic             rsp1_valid;
    logic             rsp1_ready;
    logic [WIDTH-1:0] rsp1_data;

    // Shared combinational ALU
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [3:0]       alu_op;
    logic [WIDTH-1:0] alu_result;

    // Status
    logic             busy;
    logic [CNT_W-1:0] op_count;

    // Arbiter side
    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        input  req1_valid, req1_a, req1_b, req1_op,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp0_data, rsp1_valid, rsp1_data,
        input  rsp0_ready, rsp1_ready,
        output alu_a, alu_b, alu_op,
        input  alu_result,
        output busy, op_count
    );

    // Requester side (both requesters plus status observation)
    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        output req1_valid, req1_a, req1_b, req1_op,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp0_data, rsp1_valid, rsp1_data,
        output rsp0_ready, rsp1_ready,
        input  busy, op_count
    );

    // ALU side
    modport alu (
        input  alu_a, alu_b, alu_op,
        output alu_result
    );
endinterface
`default_nettype wire

// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_share_arbiter
// Purpose  : Round-robin sharing of one combinational ALU between two
//            requesters; one operation in flight, result returned on the
//            owning requester's response channel with backpressure.
// Revision : 1.0 - initial release
// ============================================================================
module alu_share_arbiter #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    alu_share_arbiter_if.slave bus_io
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]       state_q,      state_d;
    logic             last_grant_q, last_grant_d;
    logic             owner_q,      owner_d;
    logic [WIDTH-1:0] a_q,          a_d;
    logic [WIDTH-1:0] b_q,          b_d;
    logic [3:0]       op_q,         op_d;
    logic [WIDTH-1:0] result_q,     result_d;
    logic [CNT_W-1:0] cnt_q,        cnt_d;

    logic w_idle;
    logic w_grant0;
    logic w_grant1;
    logic w_acc0;
    logic w_acc1;
    logic w_rsp_hs;

    // Round-robin tie-break: last_grant==1 means port 0 wins the next tie.
    // Ready is forced low while reset is asserted so no port sees a
    // spurious acceptance during reset.
    always_comb begin
        w_idle   = (state_q == S_IDLE);
        w_grant0 = bus_io.req0_valid & (~bus_io.req1_valid | last_grant_q);
        w_grant1 = bus_io.req1_valid & ~w_grant0;
        w_acc0   = rst_n & w_idle & w_grant0;
        w_acc1   = rst_n & w_idle & w_grant1;
        w_rsp_hs = (state_q == S_RESP) &
                   (owner_q ? bus_io.rsp1_ready : bus_io.rsp0_ready);
    end

    // Next-state and datapath load logic for the IDLE/EXEC/RESP sequence.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        a_d          = a_q;
        b_d          = b_q;
        op_d         = op_q;
        result_d     = result_q;
        cnt_d        = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (w_acc0 | w_acc1) begin
                    a_d          = w_acc1 ? bus_io.req1_a  : bus_io.req0_a;
                    b_d          = w_acc1 ? bus_io.req1_b  : bus_io.req0_b;
                    op_d         = w_acc1 ? bus_io.req1_op : bus_io.req0_op;
                    owner_d      = w_acc1;
                    last_grant_d = w_acc1;
                    state_d      = S_EXEC;
                end
            end
            S_EXEC: begin
                // The ALU is purely combinational on the operand registers,
                // so its output is settled one cycle after acceptance.
                result_d = bus_io.alu_result;
                state_d  = S_RESP;
            end
            S_RESP: begin
                if (w_rsp_hs) begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; an in-flight operation is discarded on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= '0;
            result_q     <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            a_q          <= a_d;
            b_q          <= b_d;
            op_q         <= op_d;
            result_q     <= result_d;
            cnt_q        <= cnt_d;
        end
    end

    // Output drive: ALU operands straight from registers, response data
    // gated to zero whenever the matching valid is low.
    always_comb begin
        bus_io.req0_ready = w_acc0;
        bus_io.req1_ready = w_acc1;
        bus_io.rsp0_valid = (state_q == S_RESP) & ~owner_q;
        bus_io.rsp1_valid = (state_q == S_RESP) &  owner_q;
        bus_io.rsp0_data  = bus_io.rsp0_valid ? result_q : '0;
        bus_io.rsp1_data  = bus_io.rsp1_valid ? result_q : '0;
        bus_io.alu_a      = a_q;
        bus_io.alu_b      = b_q;
        bus_io.alu_op     = op_q;
        bus_io.busy       = ~w_idle;
        bus_io.op_count   = cnt_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_share_arbiter
// Purpose  : Self-checking bench: directed handshake scenarios followed by
//            randomized traffic checked against a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_share_arbiter;

    localparam int W  = 8;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_share_arbiter_if #(.WIDTH(W), .CNT_W(CW)) bus ();

    alu_share_arbiter #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_io (bus)
    );

    // Behavioural ALU: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU,
    // 7 SLL; anything else yields 0.
    function automatic logic [7:0] alu_ref(logic [7:0] a, logic [7:0] b, logic [3:0] op);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return ($signed(a) < $signed(b)) ? 8'd1 : 8'd0;
            4'd6:    return (a < b) ? 8'd1 : 8'd0;
            4'd7:    return a << b[2:0];
            default: return 8'd0;
        endcase
    endfunction

    assign bus.alu_result = alu_ref(bus.alu_a, bus.alu_b, bus.alu_op);

    int total = 0;
    int bad   = 0;
    int exp_cnt   = 0;
    int last_port = 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input int p, input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
        if (p == 1) begin
            bus.req1_a = a; bus.req1_b = b; bus.req1_op = op;
        end else begin
            bus.req0_a = a; bus.req0_b = b; bus.req0_op = op;
        end
    endtask

    // One complete transaction from an IDLE point between edges: present the
    // valids, expect 'win' to be granted, stall its response for 'stall'
    // cycles, and check the returned data against 'expd'.
    task automatic xact(input bit v0, input bit v1, input int win, input int stall,
                        input logic [7:0] expd, input string tag);
        logic [7:0] wa;
        wa = (win == 1) ? bus.req1_a : bus.req0_a;
        bus.req0_valid = v0;
        bus.req1_valid = v1;
        if (win == 1) bus.rsp1_ready = (stall == 0);
        else          bus.rsp0_ready = (stall == 0);
        #1;
        chk({tag, ":rdy0"}, bus.req0_ready, (win == 0));
        chk({tag, ":rdy1"}, bus.req1_ready, (win == 1));
        chk({tag, ":busy_idle"}, bus.busy, 0);
        @(posedge clk); #1;
        if (win == 1) bus.req1_valid = 1'b0;
        else          bus.req0_valid = 1'b0;
        @(negedge clk);
        chk({tag, ":busy_exec"}, bus.busy, 1);
        chk({tag, ":rspv_exec"}, (win == 1) ? bus.rsp1_valid : bus.rsp0_valid, 0);
        chk({tag, ":alu_a"}, bus.alu_a, wa);
        for (int s = 0; s <= stall; s++) begin
            @(negedge clk);
            if (s == stall) begin
                if (win == 1) bus.rsp1_ready = 1'b1;
                else          bus.rsp0_ready = 1'b1;
            end
            chk({tag, ":rspv"}, (win == 1) ? bus.rsp1_valid : bus.rsp0_valid, 1);
            chk({tag, ":rspd"}, (win == 1) ? bus.rsp1_data  : bus.rsp0_data,  expd);
            chk({tag, ":rspv_other"}, (win == 1) ? bus.rsp0_valid : bus.rsp1_valid, 0);
            chk({tag, ":rdy_wait"}, {bus.req0_ready, bus.req1_ready}, 0);
            chk({tag, ":busy_resp"}, bus.busy, 1);
        end
        @(negedge clk);
        exp_cnt++;
        last_port = win;
        chk({tag, ":busy_done"}, bus.busy, 0);
        chk({tag, ":op_count"}, bus.op_count, exp_cnt);
        chk({tag, ":rspv_done"}, {bus.rsp0_valid, bus.rsp1_valid}, 0);
        chk({tag, ":rspd_done"}, {bus.rsp0_data, bus.rsp1_data}, 0);
        chk({tag, ":rdy_other"}, (win == 1) ? bus.req0_ready : bus.req1_ready,
            (win == 1) ? bus.req0_valid : bus.req1_valid);
    endtask

    // Transaction-level model state for the random phase
    bit         m_inflight;
    int         m_owner;
    int         m_acc_cyc;
    int         m_cnt;
    int         m_lp;
    logic [7:0] m_data;
    bit         acc0, acc1;
    bit         e0, e1, rv0, rv1;

    initial begin
        rst_n = 1'b0;
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
        set_op(0, 8'h11, 8'h22, 4'd0);
        set_op(1, 8'h33, 8'h44, 4'd0);
        bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;

        // Reset state (valids held high to prove ready is suppressed)
        @(negedge clk);
        chk("rst:rdy", {bus.req0_ready, bus.req1_ready}, 0);
        chk("rst:rspv", {bus.rsp0_valid, bus.rsp1_valid}, 0);
        chk("rst:rspd", {bus.rsp0_data, bus.rsp1_data}, 0);
        chk("rst:alu", {bus.alu_a, bus.alu_b, bus.alu_op}, 0);
        chk("rst:busy", bus.busy, 0);
        chk("rst:cnt", bus.op_count, 0);
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single ADD on port 0
        set_op(0, 8'd5, 8'd3, 4'b0000);
        xact(1, 0, 0, 0, 8'd8, "add");

        // Signed SLT on port 1, then swapped operands
        set_op(1, 8'hFF, 8'h01, 4'b0101);
        xact(0, 1, 1, 0, 8'd1, "slt");
        set_op(1, 8'h01, 8'hFF, 4'b0101);
        xact(0, 1, 1, 0, 8'd0, "slt_swap");

        // Contention: grants alternate 0,1,0,1
        set_op(0, 8'd10, 8'd4, 4'b0001);
        set_op(1, 8'hF0, 8'h0F, 4'b0100);
        for (int i = 0; i < 4; i++)
            xact(1, 1, i % 2, 0, (i % 2) ? 8'hFF : 8'd6, "cont");

        // Backpressure on port 0 with port 1 waiting
        set_op(0, 8'd7, 8'd9, 4'b0000);
        set_op(1, 8'd3, 8'd1, 4'b0001);
        xact(1, 1, 0, 5, 8'd16, "bp");
        xact(0, 1, 1, 0, 8'd2, "bp_after");

        // Async reset during EXEC
        set_op(0, 8'h12, 8'h34, 4'b0000);
        bus.req0_valid = 1'b1;
        #1;
        chk("arst:accept", bus.req0_ready, 1);
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b1;
        @(negedge clk);
        chk("arst:exec_busy", bus.busy, 1);
        chk("arst:exec_rdy1", bus.req1_ready, 0);
        rst_n = 1'b0;
        #1;
        chk("arst:busy", bus.busy, 0);
        chk("arst:rdy", {bus.req0_ready, bus.req1_ready}, 0);
        chk("arst:alu", {bus.alu_a, bus.alu_b, bus.alu_op}, 0);
        chk("arst:rspv", {bus.rsp0_valid, bus.rsp1_valid}, 0);
        chk("arst:cnt", bus.op_count, 0);
        @(negedge clk);
        bus.req1_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_cnt = 0;
        last_port = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("arst:no_rsp", {bus.rsp0_valid, bus.rsp1_valid, bus.busy}, 0);
        end
        set_op(0, 8'd1, 8'd2, 4'b0000);
        set_op(1, 8'd9, 8'd5, 4'b0001);
        xact(1, 1, 0, 0, 8'd3, "arst_tie");
        xact(0, 1, 1, 0, 8'd4, "arst_req1");

        // Undefined opcode
        set_op(0, 8'h55, 8'h22, 4'b1010);
        xact(1, 0, 0, 0, 8'h00, "illegal");

        // Randomized traffic against the transaction-level model
        m_inflight = 1'b0;
        m_owner    = 0;
        m_acc_cyc  = 0;
        m_cnt      = exp_cnt;
        m_lp       = last_port;
        m_data     = 8'h00;
        acc0 = 1'b0; acc1 = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            if (acc0) bus.req0_valid = 1'b0;
            else if (!bus.req0_valid) begin
                if ($urandom_range(0, 1) == 1) begin
                    bus.req0_valid = 1'b1;
                    set_op(0, 8'($urandom), 8'($urandom), 4'($urandom_range(0, 15)));
                end
            end else if ($urandom_range(0, 7) == 0) bus.req0_valid = 1'b0;
            if (acc1) bus.req1_valid = 1'b0;
            else if (!bus.req1_valid) begin
                if ($urandom_range(0, 1) == 1) begin
                    bus.req1_valid = 1'b1;
                    set_op(1, 8'($urandom), 8'($urandom), 4'($urandom_range(0, 15)));
                end
            end else if ($urandom_range(0, 7) == 0) bus.req1_valid = 1'b0;
            bus.rsp0_ready = ($urandom_range(0, 3) != 0);
            bus.rsp1_ready = ($urandom_range(0, 3) != 0);
            acc0 = 1'b0; acc1 = 1'b0;
            #1;
            e0  = !m_inflight && bus.req0_valid && (!bus.req1_valid || m_lp == 1);
            e1  = !m_inflight && bus.req1_valid && !e0;
            rv0 = m_inflight && m_owner == 0 && cyc >= m_acc_cyc + 2;
            rv1 = m_inflight && m_owner == 1 && cyc >= m_acc_cyc + 2;
            chk("rnd:rdy0", bus.req0_ready, e0);
            chk("rnd:rdy1", bus.req1_ready, e1);
            chk("rnd:busy", bus.busy, m_inflight);
            chk("rnd:rspv0", bus.rsp0_valid, rv0);
            chk("rnd:rspv1", bus.rsp1_valid, rv1);
            chk("rnd:rspd0", bus.rsp0_data, rv0 ? m_data : 8'h00);
            chk("rnd:rspd1", bus.rsp1_data, rv1 ? m_data : 8'h00);
            chk("rnd:cnt", bus.op_count, m_cnt);
            if (e0 || e1) begin
                m_inflight = 1'b1;
                m_owner    = e1 ? 1 : 0;
                m_data     = e1 ? alu_ref(bus.req1_a, bus.req1_b, bus.req1_op)
                                : alu_ref(bus.req0_a, bus.req0_b, bus.req0_op);
                m_acc_cyc  = cyc;
                m_lp       = m_owner;
                acc0       = e0;
                acc1       = e1;
            end else if ((rv0 && bus.rsp0_ready) || (rv1 && bus.rsp1_ready)) begin
                m_inflight = 1'b0;
                m_cnt++;
            end
        end

        // Drain
        @(negedge clk);
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
        repeat (4) @(negedge clk);
        chk("drain:busy", bus.busy, 0);
        chk("drain:cnt", bus.op_count, m_cnt + (m_inflight ? 1 : 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one combinational 8-bit ALU instance in the EX stage between two requesters: port 0 (pipeline EX issue) and port 1 (auxiliary/debug or future co-unit).
- Arbitrates round-robin and registers the granted operands to drive the ALU.
- Captures the ALU result and returns it on the owning requester's response channel with valid/ready backpressure.
- One operation in flight at a time.

Parameters:
- WIDTH, 8, operand/result width; must match the ALU instance.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle when high with valid
- req0_a  in  WIDTH  operand A, req 0
- req0_b  in  WIDTH  operand B, req 0
- req0_op  in  4  ALU opcode, req 0
- req1_valid, req1_ready, req1_a, req1_b, req1_op: same as above, requester 1
- rsp0_valid  out  1  result available for requester 0
- rsp0_ready  in  1  requester 0 consumes result
- rsp0_data  out  WIDTH  result for requester 0
- rsp1_valid, rsp1_ready, rsp1_data: same as above, requester 1
- alu_a  out  WIDTH  to ALU operand A
- alu_b  out  WIDTH  to ALU operand B
- alu_op  out  4  to ALU opcode
- alu_result  in  WIDTH  from ALU result (combinational)
- busy  out  1  high whenever state != IDLE
- op_count  out  CNT_W  number of completed responses since reset

Behaviour:
- Reset (async, rst_n=0): state=IDLE, last_grant=1 (req0 wins first tie), operand regs=0, result reg=0, owner=0, op_count=0.
- Reset outputs:
  - all ready/valid = 0;
  - rsp*_data = 0;
  - alu_a/alu_b/alu_op = 0;
  - busy = 0.
- Reset mid-operation: in-flight operation is silently dropped; no response is issued after release.
- FSM states: IDLE, EXEC, RESP.
- IDLE arbitration (combinational):
  - grant0 = req0_valid & (!req1_valid | last_grant==1);
  - grant1 = req1_valid & !grant0;
  - reqN_ready = (state==IDLE) & grantN. Ready is never high for both ports in the same cycle.
- IDLE, acceptance (valid & ready at edge): latch a/b/op into operand regs, owner=N, last_grant=N, go to EXEC. With no valid, stay in IDLE.
- EXEC (exactly 1 cycle): alu_a/alu_b/alu_op are driven from the operand regs (always, in every state). At the edge, alu_result is captured into the result reg; go to RESP.
- RESP: rsp[owner]_valid=1 and rsp[owner]_data=result reg; the other port's rsp_valid=0. Hold until rsp[owner]_ready=1, then go to IDLE and increment op_count at that edge.
- rspN_data = result reg while rspN_valid is high, else 0.
- Latency:
  - accept at edge k → rsp_valid high from edge k+2.
  - Minimum spacing between accepts is 3 cycles (accept, EXEC, RESP with ready=1, back to IDLE).
- Requester rules:
  - Requester holds valid/operands stable until ready.
  - Valid may drop before acceptance; the arbiter re-evaluates every IDLE cycle.
  - Requests presented during EXEC/RESP wait (ready=0).
- Fairness: with both valid continuously, grants strictly alternate 0,1,0,1...
- Opcodes are passed through unmodified. Undefined opcodes (1000–1111) return the ALU's default result 0 through the normal response path; there is no error flag.
- op_count wraps modulo 2^CNT_W.
- No combinational path from rsp_ready to req_ready. The only comb paths are reqN_valid → reqM_ready, and alu_result is only sampled by a register.

Test Plan:
- Single ADD: req0 a=8'd5, b=8'd3, op=0000, rsp0_ready=1 → req0_ready high in the accept cycle; rsp0_valid=1, rsp0_data=8'd8 at edge k+2 for 1 cycle; op_count=1; busy high for 2 cycles.
- Signed SLT on port 1: a=8'hFF, b=8'h01, op=0101 → rsp1_data=8'd1. Swapped operands → 8'd0. rsp0_valid stays 0 throughout.
- Contention: both valid continuously for 4 ops (req0 SUB 10-4, req1 XOR F0^0F) → grant order 0,1,0,1; results 8'd6, 8'hFF, 8'd6, 8'hFF on the correct ports; op_count=4.
- Backpressure: rsp0_ready=0 for 5 cycles after rsp0_valid → rsp0_valid/data held stable; req1_valid waiting sees req1_ready=0 until the cycle after rsp0 handshake.
- Async reset mid-op: assert rst_n low during EXEC → all outputs 0 immediately; after release, no rsp_valid; the next req1 request is served with the same 2-cycle latency and req0 wins the first tie.
- Illegal opcode 4'b1010 with a=8'h55, b=8'h22 → rsp0_data=8'h00, normal handshake, op_count increments.
